// File: rtl/enc16_queue.sv
// rtl/enc16_queue.sv - sequential 16-to-4 encoder: pending request bits drained as codes over valid/ready
// Define ENC16_RR_EN for round-robin priority; otherwise fixed priority per LOW_FIRST.
module enc16_queue #(
  parameter bit LOW_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] req,
  input  logic        ready,
  output logic [3:0]  code,
  output logic        valid,
  output logic [15:0] pending,
  output logic        busy
);

  localparam logic [0:0] S_IDLE    = 1'b0;
  localparam logic [0:0] S_PRESENT = 1'b1;

  logic [0:0]  state;
  logic        accept;
  logic [15:0] clr;
  logic [15:0] nxt;
  logic [3:0]  sel_code;

  assign accept = valid && ready;
  assign clr    = accept ? (16'h0001 << code) : 16'h0000;
  // In IDLE clr is zero, so nxt is pending|req; while presenting it is the remainder.
  assign nxt    = (pending & ~clr) | req;
  assign busy   = |pending;

`ifdef ENC16_RR_EN
  logic [3:0] last;
  logic [3:0] base;

  // The code being accepted this cycle counts as the most recent grant.
  assign base = accept ? code : last;

  function automatic logic [3:0] rr_pick(input logic [15:0] x, input logic [3:0] b);
    logic [3:0] start;
    logic [3:0] idx;
    logic [3:0] r;
    start = b + 4'd1;
    r     = start;
    for (int k = 15; k >= 0; k--) begin
      idx = start + k[3:0];
      if (x[idx]) r = idx;
    end
    return r;
  endfunction

  always_comb begin
    sel_code = rr_pick(nxt, base);
  end
`else
  function automatic logic [3:0] fixed_pick(input logic [15:0] x);
    logic [3:0] r;
    r = 4'd0;
    if (LOW_FIRST) begin
      for (int i = 15; i >= 0; i--) if (x[i]) r = i[3:0];
    end else begin
      for (int i = 0; i < 16; i++) if (x[i]) r = i[3:0];
    end
    return r;
  endfunction

  always_comb begin
    sel_code = fixed_pick(nxt);
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      pending <= 16'h0000;
      code    <= 4'd0;
      valid   <= 1'b0;
`ifdef ENC16_RR_EN
      last    <= 4'd15;
`endif
    end else begin
      pending <= nxt;
`ifdef ENC16_RR_EN
      if (accept) last <= code;
`endif
      case (state)
        S_IDLE: begin
          if (|nxt) begin
            code  <= sel_code;
            valid <= 1'b1;
            state <= S_PRESENT;
          end else begin
            valid <= 1'b0;
          end
        end
        S_PRESENT: begin
          // Hold the presented code under backpressure, even if higher priority arrives.
          if (ready) begin
            if (|nxt) begin
              code <= sel_code;
            end else begin
              valid <= 1'b0;
              state <= S_IDLE;
            end
          end
        end
        default: begin
          valid <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_enc16_queue.sv
// tb/tb_enc16_queue.sv - self-checking bench for enc16_queue (vector table, corner sequences, random vs model)
module tb_enc16_queue;

  localparam bit LOW_FIRST = 1'b1;

  logic        clk;
  logic        rst_n;
  logic [15:0] req;
  logic        ready;
  logic [3:0]  code;
  logic        valid;
  logic [15:0] pending;
  logic        busy;

  int n_checks;
  int n_fail;

  enc16_queue #(.LOW_FIRST(LOW_FIRST)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .ready(ready),
    .code(code), .valid(valid), .pending(pending), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] req;
    logic        ready;
    logic        exp_valid;
    logic [3:0]  exp_code;
    logic [15:0] exp_pending;
  } vec_t;

  // Reference model: a set of outstanding indices plus the presented code.
  logic [15:0] m_pending;
  logic        m_valid;
  logic [3:0]  m_code;
  logic [3:0]  m_last;

  function automatic logic [3:0] lowest_idx(input logic [15:0] x);
    logic [15:0] iso;
    iso = x & (~x + 16'd1);
    return 4'($clog2(iso));
  endfunction

  function automatic logic [3:0] pick(input logic [15:0] x, input logic [3:0] prev);
`ifdef ENC16_RR_EN
    logic [31:0] dbl;
    logic [15:0] rot;
    logic [3:0]  start;
    start = prev + 4'd1;
    dbl   = {x, x} >> start;
    rot   = dbl[15:0];
    return start + lowest_idx(rot);
`else
    logic [16:0] xp;
    xp = {1'b0, x} + 17'd1;
    if (LOW_FIRST) return lowest_idx(x);
    return 4'($clog2(xp) - 1);
`endif
  endfunction

  task automatic model_reset();
    m_pending = 16'h0000;
    m_valid   = 1'b0;
    m_code    = 4'd0;
    m_last    = 4'd15;
  endtask

  task automatic model_step(input logic [15:0] r, input logic rd);
    logic        acc;
    logic [15:0] nx;
    logic [3:0]  prev;
    acc  = m_valid && rd;
    nx   = m_pending;
    prev = acc ? m_code : m_last;
    if (acc) begin
      nx[m_code] = 1'b0;
      m_last = m_code;
    end
    nx = nx | r;
    if (!m_valid || rd) begin
      if (nx != 16'h0000) begin
        m_code  = pick(nx, prev);
        m_valid = 1'b1;
      end else begin
        m_valid = 1'b0;
      end
    end
    m_pending = nx;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input logic [15:0] r, input logic rd);
    req   = r;
    ready = rd;
    model_step(r, rd);
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, ".valid"}, 32'(valid), 32'(m_valid));
    check({tag, ".pending"}, 32'(pending), 32'(m_pending));
    check({tag, ".busy"}, 32'(busy), 32'(m_pending != 16'h0000));
    if (m_valid) check({tag, ".code"}, 32'(code), 32'(m_code));
  endtask

  task automatic do_reset();
    req   = 16'h0000;
    ready = 1'b0;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

`ifndef ENC16_RR_EN
  vec_t tbl[16];
`endif

  initial begin
    n_checks = 0;
    n_fail   = 0;
    do_reset();

    check("reset.valid", 32'(valid), 32'd0);
    check("reset.code", 32'(code), 32'd0);
    check("reset.pending", 32'(pending), 32'd0);
    check("reset.busy", 32'(busy), 32'd0);

`ifndef ENC16_RR_EN
    // Single one-hot, multi-hot drain, backpressure, clear/set collision.
    tbl[0]  = '{16'h0020, 1'b1, 1'b1, 4'd5,  16'h0020};
    tbl[1]  = '{16'h0000, 1'b1, 1'b0, 4'd0,  16'h0000};
    tbl[2]  = '{16'h8101, 1'b1, 1'b1, 4'd0,  16'h8101};
    tbl[3]  = '{16'h0000, 1'b1, 1'b1, 4'd8,  16'h8100};
    tbl[4]  = '{16'h0000, 1'b1, 1'b1, 4'd15, 16'h8000};
    tbl[5]  = '{16'h0000, 1'b1, 1'b0, 4'd0,  16'h0000};
    tbl[6]  = '{16'h0006, 1'b0, 1'b1, 4'd1,  16'h0006};
    tbl[7]  = '{16'h0000, 1'b0, 1'b1, 4'd1,  16'h0006};
    tbl[8]  = '{16'h0000, 1'b0, 1'b1, 4'd1,  16'h0006};
    tbl[9]  = '{16'h0000, 1'b0, 1'b1, 4'd1,  16'h0006};
    tbl[10] = '{16'h0000, 1'b0, 1'b1, 4'd1,  16'h0006};
    tbl[11] = '{16'h0000, 1'b1, 1'b1, 4'd2,  16'h0004};
    tbl[12] = '{16'h0000, 1'b1, 1'b0, 4'd0,  16'h0000};
    tbl[13] = '{16'h0008, 1'b0, 1'b1, 4'd3,  16'h0008};
    tbl[14] = '{16'h0008, 1'b1, 1'b1, 4'd3,  16'h0008};
    tbl[15] = '{16'h0000, 1'b1, 1'b0, 4'd0,  16'h0000};
    for (int i = 0; i < 16; i++) begin
      tick(tbl[i].req, tbl[i].ready);
      check($sformatf("vec%0d.valid", i), 32'(valid), 32'(tbl[i].exp_valid));
      check($sformatf("vec%0d.pending", i), 32'(pending), 32'(tbl[i].exp_pending));
      if (tbl[i].exp_valid) check($sformatf("vec%0d.code", i), 32'(code), 32'(tbl[i].exp_code));
    end

    // Higher-priority arrival under backpressure must not displace the presented code.
    tick(16'h0010, 1'b0);
    tick(16'h0001, 1'b0);
    check("hold.code", 32'(code), 32'd4);
    check("hold.pending", 32'(pending), 32'h0011);
    tick(16'h0000, 1'b1);
    check("hold.next", 32'(code), 32'd0);
    tick(16'h0000, 1'b1);
    check("hold.drain", 32'(valid), 32'd0);
`else
    // Constant contention on 0 and 4 must alternate.
    for (int i = 0; i < 8; i++) begin
      tick(16'h0011, 1'b1);
      check($sformatf("rr%0d.valid", i), 32'(valid), 32'd1);
      check($sformatf("rr%0d.code", i), 32'(code), (i % 2 == 0) ? 32'd0 : 32'd4);
    end
    tick(16'h0000, 1'b1);
    tick(16'h0000, 1'b1);
    check("rr.drain", 32'(valid), 32'd0);
`endif

    // Asynchronous reset between edges, with requests held during reset.
    tick(16'hFFFF, 1'b0);
    check("arst.pre_pending", 32'(pending), 32'hFFFF);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst.valid", 32'(valid), 32'd0);
    check("arst.pending", 32'(pending), 32'd0);
    check("arst.code", 32'(code), 32'd0);
    check("arst.busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    check("arst.held_pending", 32'(pending), 32'd0);
    #2;
    req   = 16'h0000;
    rst_n = 1'b1;
    model_reset();
    tick(16'h0000, 1'b0);
    check("arst.idle_valid", 32'(valid), 32'd0);
    check("arst.idle_pending", 32'(pending), 32'd0);
    tick(16'h0004, 1'b1);
    check("arst.first_valid", 32'(valid), 32'd1);
    check("arst.first_code", 32'(code), 32'd2);

    // Random sparse requests and ready against the model.
    for (int i = 0; i < 400; i++) begin
      logic [15:0] r;
      logic        rd;
      r  = 16'($urandom) & 16'($urandom) & 16'($urandom);
      if ($urandom_range(0, 3) == 0) r = 16'h0000;
      rd = ($urandom_range(0, 3) != 0);
      tick(r, rd);
      check_model($sformatf("rand%0d", i));
    end
    for (int i = 0; i < 20; i++) begin
      tick(16'h0000, 1'b1);
      check_model($sformatf("flush%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/enc16_queue.md
Name: enc16_queue

Overview:
- Sequential 16-to-4 encoder: the inverse of the team's 4-to-16 one-hot decoder.
- Captures one-hot or multi-hot request lines into a 16-bit pending register and emits one 4-bit binary code per pending bit.
- Codes are emitted in priority order over a valid/ready handshake; each bit is cleared when its code is accepted.
- Sits between event sources (buttons, FSM strobes) and a consumer that drives the 16-output decoder.

Parameters:
- LOW_FIRST, 1: 1 = lowest set index has priority (bit 0 first); 0 = highest index first (bit 15 first).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req  input  16  request strobes; any bit high for one or more cycles sets the matching pending bit
- ready  input  1  consumer accepts code this cycle when valid=1
- code  output  4  binary index of the presented request; register output
- valid  output  1  code is meaningful; register output
- pending  output  16  current pending register, excluding nothing (includes the bit currently presented)
- busy  output  1  OR of pending; combinational from the register

Behaviour:
- Reset (rst_n low, asynchronous): pending=0, code=0, valid=0, state=IDLE. Pending reset has precedence over any req.
- Pending update each edge: pending <= (pending & ~clr) | req.
  - clr is the one-hot of code when valid&&ready, else 0.
  - A req bit equal to the bit being cleared in the same cycle re-sets it: new request wins, no event lost.
  - Repeated req on an already-pending bit merges into one code. The queue depth is one per index, with no counting.
- State machine: IDLE, PRESENT.
  - IDLE: let nxt = (pending | req). If nxt != 0: code <= prio(nxt), valid <= 1, go PRESENT. Else stay, valid=0.
  - PRESENT: code and valid are held stable while ready=0, even if higher-priority requests arrive.
  - PRESENT with ready=1: let rem = ((pending & ~clr) | req).
    - If rem != 0: code <= prio(rem), valid stays 1, stay PRESENT. This gives back-to-back codes with no bubble.
    - Else: valid <= 0, go IDLE.
- prio(x) returns the lowest set index if LOW_FIRST=1, otherwise the highest. The x=0 case is unreachable by construction.
- Latency: req high at edge n while IDLE gives valid=1 and the correct code after edge n. Throughput is one code per cycle while ready=1.
- When valid=0, code holds its last value. The bench must not check code while valid=0.
- Reset mid-operation: all state clears immediately. Requests asserted during reset are dropped.

Optional Feature:
- Macro ENC16_RR_EN.
- Defined:
  - Priority is round-robin. A 4-bit last register records each accepted code.
  - The search starts at last+1 mod 16 and wraps 15->0 (LOW_FIRST ignored).
  - last resets to 4'd15, so the first search starts at index 0.
- Undefined: fixed priority per LOW_FIRST; no last register is instantiated.

Test Plan:
- Single one-hot: req=16'h0020 for 1 cycle, ready=1 -> valid=1, code=4'd5 one cycle later; then valid=0, pending=0.
- Multi-hot fixed priority (LOW_FIRST=1): req=16'h8101 one cycle, ready=1 -> codes 0, 8, 15 on three consecutive cycles, no bubble, then valid=0.
- Backpressure: req=16'h0006, ready=0 for 5 cycles -> code=1 stable, valid=1, pending=16'h0006. Then ready=1 -> codes 1 then 2.
- Clear/set collision: code=3 presented; in the accept cycle req=16'h0008 -> pending bit 3 stays set, code 3 presented again next.
- Async reset mid-stream: pending=16'hFFFF, assert rst_n low between edges -> valid=0, pending=0, code=0 immediately. Release -> idle until the next req.
- With ENC16_RR_EN: req=16'h0011 every cycle, ready=1 -> codes alternate 0, 4, 0, 4, ... and no index is starved.
